uart_tx_queue: RTL and testbench

//  Byte queue and launcher in front of the UART transmitter. Bus-side writes land in a

---
 rtl/uart_pkg.sv | 25 ++
 rtl/txq_fifo.sv | 72 +++++++
 rtl/uart_tx_queue.sv | 131 +++++++++++++
 tb/tb_uart_tx_queue.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, transmit-queue address width and the
// launcher state encoding used by uart_tx_queue.
package uart_pkg;

   localparam int UART_DBIT   = 8;
   localparam int UART_TXQ_AW = 4;

   // Launcher states: IDLE waits for data, LAUNCH drives the one-cycle start
   // pulse, WAIT holds until the transmitter reports completion.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2
   } txq_state_t;

   // Occupancy from wrap-bit pointers; the extra msb makes full distinguishable
   // from empty.
   function automatic logic [UART_TXQ_AW:0] txq_ptr_diff(
      input logic [UART_TXQ_AW:0] wr_ptr,
      input logic [UART_TXQ_AW:0] rd_ptr
   );
      return wr_ptr - rd_ptr;
   endfunction

endpackage

// File: rtl/txq_fifo.sv
// Circular byte FIFO for the UART transmit queue.
// Pointers are ADDR_W+1 bits; the msb is a wrap bit so full and empty are
// both derived from pointer compares with no extra counter.
// Optional macro UART_TXQ_LEVEL_EN adds the o_level occupancy output.
module txq_fifo #(
   parameter int DBIT   = 8,
   parameter int ADDR_W = 4
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_wr,
   input  logic [DBIT-1:0]   i_wr_data,
   input  logic              i_rd,
   output logic [DBIT-1:0]   o_rd_data,
`ifdef UART_TXQ_LEVEL_EN
   output logic [ADDR_W:0]   o_level,
`endif
   output logic              o_full,
   output logic              o_empty
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

   logic [DBIT-1:0] r_mem [0:DEPTH-1];
   logic [ADDR_W:0] r_wr_ptr;
   logic [ADDR_W:0] r_rd_ptr;
   logic            w_do_wr;
   logic            w_do_rd;

   // A write into a full queue is refused even if a pop happens the same
   // cycle; a pop from an empty queue is likewise ignored.
   assign w_do_wr = i_wr && !o_full;
   assign w_do_rd = i_rd && !o_empty;

   assign o_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                    (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
   assign o_empty = (r_wr_ptr == r_rd_ptr);

   // Head of queue; the launcher latches it on the pop cycle.
   assign o_rd_data = r_mem[r_rd_ptr[ADDR_W-1:0]];

`ifdef UART_TXQ_LEVEL_EN
   assign o_level = r_wr_ptr - r_rd_ptr;
`endif

   // Storage array: no reset, contents are only meaningful between pointers.
   always_ff @(posedge i_clk) begin
      if (w_do_wr) begin
         r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_wr_data;
      end
   end

   // Write pointer advances on every accepted push, wrapping naturally.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
      end else if (w_do_wr) begin
         r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
   end

   // Read pointer advances on every accepted pop, wrapping naturally.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_rd_ptr <= '0;
      end else if (w_do_rd) begin
         r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
   end

endmodule

// File: rtl/uart_tx_queue.sv
// Transmit byte queue and launcher in front of uart_tx.
// Bus writes are queued in txq_fifo; the launcher pops one byte, pulses
// tx_start with the byte on tx_din, then waits for tx_done_tick.
// Optional macro UART_TXQ_LEVEL_EN adds the level occupancy port.
// dbg_state exposes the launcher state for checkers.
//
// Handshake: tx_start is a single-cycle pulse with tx_din valid from that
// cycle until the next launch; the transmitter answers with a single-cycle
// tx_done_tick, which is only acted on in WAIT.
module uart_tx_queue
   import uart_pkg::*;
#(
   parameter int DBIT   = UART_DBIT,
   parameter int ADDR_W = UART_TXQ_AW
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [DBIT-1:0]   wr_data,
   input  logic              clr_ovf,
   output logic              full,
   output logic              empty,
   output logic              overflow,
   output logic              tx_busy,
   output logic              tx_start,
   output logic [DBIT-1:0]   tx_din,
   input  logic              tx_done_tick,
`ifdef UART_TXQ_LEVEL_EN
   output logic [ADDR_W:0]   level,
`endif
   output txq_state_t        dbg_state
);

   txq_state_t       r_state;
   txq_state_t       w_state_nxt;
   logic             w_pop;
   logic [DBIT-1:0]  w_head;
   logic             w_full;
   logic             w_empty;
   logic             r_overflow;
   logic             r_tx_busy;
   logic             r_tx_start;
   logic [DBIT-1:0]  r_tx_din;

   txq_fifo #(
      .DBIT   (DBIT),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .i_clk     (clk),
      .i_reset   (reset),
      .i_wr      (wr_en),
      .i_wr_data (wr_data),
      .i_rd      (w_pop),
      .o_rd_data (w_head),
`ifdef UART_TXQ_LEVEL_EN
      .o_level   (level),
`endif
      .o_full    (w_full),
      .o_empty   (w_empty)
   );

   // Launcher next-state: pop in IDLE when data waits, one LAUNCH cycle,
   // then hold in WAIT until the transmitter finishes.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = LAUNCH;
            end
         end
         LAUNCH: begin
            w_state_nxt = WAIT;
         end
         WAIT: begin
            if (tx_done_tick) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State register plus registered start/busy flags decoded from next state,
   // so both outputs line up exactly with the state they describe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_tx_start <= 1'b0;
         r_tx_busy  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_tx_start <= (w_state_nxt == LAUNCH);
         r_tx_busy  <= (w_state_nxt != IDLE);
      end
   end

   // Launch data register: captures the head on the pop cycle and holds it
   // until the next launch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tx_din <= '0;
      end else if (w_pop) begin
         r_tx_din <= w_head;
      end
   end

   // Sticky overflow: a refused write sets it and wins over a same-cycle clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_overflow <= 1'b0;
      end else if (wr_en && w_full) begin
         r_overflow <= 1'b1;
      end else if (clr_ovf) begin
         r_overflow <= 1'b0;
      end
   end

   assign full      = w_full;
   assign empty     = w_empty;
   assign overflow  = r_overflow;
   assign tx_busy   = r_tx_busy;
   assign tx_start  = r_tx_start;
   assign tx_din    = r_tx_din;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue: a per-cycle vector table for the single
// byte launch, then hand-written sequences for back-to-back traffic, overflow,
// full-plus-pop collision and reset while a byte is in flight.
module tb_uart_tx_queue;
  import uart_pkg::*;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       clr_ovf;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_din;
  logic       tx_done_tick;
`ifdef UART_TXQ_LEVEL_EN
  logic [4:0] level;
`endif
  txq_state_t dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt = 0;
  int start_times[$];
  logic [7:0] exp_q[$];

  // transmitter model controls
  logic done_man;
  logic auto_en;
  logic m_done;
  int   auto_delay;
  int   m_cnt;

  assign tx_done_tick = auto_en ? m_done : done_man;

  uart_tx_queue dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .clr_ovf      (clr_ovf),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
    .tx_busy      (tx_busy),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .tx_done_tick (tx_done_tick),
`ifdef UART_TXQ_LEVEL_EN
    .level        (level),
`endif
    .dbg_state    (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard: every launch must carry the next expected byte
  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      start_cnt++;
      start_times.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_start: got din %0h expected no start", tx_din);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (tx_din !== e) begin
          errors++;
          $display("FAIL sb_din: got %0h expected %0h", tx_din, e);
        end
      end
    end
  end

  // transmitter model: done tick auto_delay cycles after each start
  always @(negedge clk) begin
    m_done = 1'b0;
    if (auto_en) begin
      if (m_cnt > 0) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) m_done = 1'b1;
      end
      if (tx_start === 1'b1) m_cnt = auto_delay;
    end else begin
      m_cnt = 0;
    end
  end

  // driver: one cycle of inputs, applied just after the rising edge
  task automatic step(input logic wr, input logic [7:0] d, input logic done, input logic clr);
    @(posedge clk);
    #1;
    wr_en = wr;
    wr_data = d;
    done_man = done;
    clr_ovf = clr;
  endtask

  task automatic wait_starts(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (start_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(name, start_cnt, target);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (tx_busy !== 1'b0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, tx_busy, 0);
  endtask

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       done;
    logic       clr;
    logic       exp_empty;
    logic       exp_full;
    logic       exp_start;
    logic [7:0] exp_din;
    logic       exp_busy;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int base;
    // write A5 in cycle 0: start in cycle 2, done in cycle 5, idle in cycle 6
    //         wr  data   done clr  emp  full start din    busy ovf
    vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};

    reset = 1'b1;
    wr_en = 1'b0;
    wr_data = 8'h00;
    clr_ovf = 1'b0;
    done_man = 1'b0;
    auto_en = 1'b0;
    auto_delay = 100;

    // 1. reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_din", tx_din, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_busy", tx_busy, 0);
    chk("rst_state", dbg_state, IDLE);
`ifdef UART_TXQ_LEVEL_EN
    chk("rst_level", level, 0);
`endif
    step(0, 8'h00, 0, 0);
    reset = 1'b0;

    // 2. single byte, table driven
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].wr_en, vecs[i].wr_data, vecs[i].done, vecs[i].clr);
      chk($sformatf("t2_empty[%0d]", i), empty, vecs[i].exp_empty);
      chk($sformatf("t2_full[%0d]", i), full, vecs[i].exp_full);
      chk($sformatf("t2_start[%0d]", i), tx_start, vecs[i].exp_start);
      chk($sformatf("t2_din[%0d]", i), tx_din, vecs[i].exp_din);
      chk($sformatf("t2_busy[%0d]", i), tx_busy, vecs[i].exp_busy);
      chk($sformatf("t2_ovf[%0d]", i), overflow, vecs[i].exp_ovf);
    end

    // 3. three back-to-back bytes, done 100 cycles after each start
    auto_en = 1'b1;
    auto_delay = 100;
    base = start_cnt;
    step(1, 8'h11, 0, 0); exp_q.push_back(8'h11);
    step(1, 8'h22, 0, 0); exp_q.push_back(8'h22);
    step(1, 8'h33, 0, 0); exp_q.push_back(8'h33);
    step(0, 8'h00, 0, 0);
    wait_starts(base + 3, 500, "t3_starts");
    chk("t3_spacing_a", start_times[base + 1] - start_times[base], 102);
    chk("t3_spacing_b", start_times[base + 2] - start_times[base + 1], 102);
    wait_idle(300, "t3_idle");
    chk("t3_empty", empty, 1);
    chk("t3_sb_drained", exp_q.size(), 0);

    // 4. fill with done held off, then overflow and clear
    auto_en = 1'b0;
    base = start_cnt;
    for (int i = 0; i < 17; i++) begin
      step(1, 8'h40 + 8'(i), 0, 0);
      exp_q.push_back(8'h40 + 8'(i));
    end
    step(0, 8'h00, 0, 0);
    chk("t4_full", full, 1);
    chk("t4_ovf_before", overflow, 0);
    chk("t4_busy", tx_busy, 1);
    step(1, 8'hEE, 0, 0);
    step(0, 8'h00, 0, 0);
    chk("t4_ovf_set", overflow, 1);
    chk("t4_still_full", full, 1);
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 0);
    chk("t4_ovf_clr", overflow, 0);
    // overflowing write together with clear: set wins
    step(1, 8'hEF, 0, 1);
    step(0, 8'h00, 0, 0);
    chk("t4_set_wins", overflow, 1);
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 0);
    chk("t4_ovf_clr2", overflow, 0);

    // 5. full queue, write lands in the same cycle as the pop
    step(0, 8'h00, 1, 0);
    chk("t5_busy_m", tx_busy, 1);
    step(1, 8'hDD, 0, 0);
    auto_en = 1'b1;
    auto_delay = 3;
    chk("t5_busy_m1", tx_busy, 0);
    chk("t5_full_m1", full, 1);
    step(0, 8'h00, 0, 0);
    chk("t5_ovf", overflow, 1);
    chk("t5_full_after", full, 0);
    chk("t5_start", tx_start, 1);
`ifdef UART_TXQ_LEVEL_EN
    chk("t5_level", level, 15);
`endif
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 0);
    wait_starts(base + 17, 200, "t5_starts");
    wait_idle(50, "t5_idle");
    chk("t5_empty", empty, 1);
    chk("t5_sb_drained", exp_q.size(), 0);

    // 6. reset in WAIT with five bytes queued
    auto_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1, 8'h60 + 8'(i), 0, 0);
      exp_q.push_back(8'h60 + 8'(i));
    end
    repeat (3) step(0, 8'h00, 0, 0);
    chk("t6_state_wait", dbg_state, WAIT);
    chk("t6_empty_pre", empty, 0);
`ifdef UART_TXQ_LEVEL_EN
    chk("t6_level_pre", level, 5);
`endif
    reset = 1'b1;
    #2;
    chk("t6_empty", empty, 1);
    chk("t6_busy", tx_busy, 0);
    chk("t6_start", tx_start, 0);
    chk("t6_din", tx_din, 0);
    chk("t6_state", dbg_state, IDLE);
    exp_q.delete();
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);
    reset = 1'b0;
    base = start_cnt;
    repeat (30) step(0, 8'h00, 0, 0);
    chk("t6_no_start", start_cnt, base);
    chk("t6_busy_after", tx_busy, 0);
    auto_en = 1'b1;
    auto_delay = 5;
    step(1, 8'h5A, 0, 0);
    exp_q.push_back(8'h5A);
    step(0, 8'h00, 0, 0);
    wait_starts(base + 1, 20, "t6_new_start");
    wait_idle(20, "t6_idle");
    chk("t6_sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
